// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the scalar/vector pipeline: stage enables, flushes, vector
// multi-cycle EX stall and saturating stall/flush counters. State moves on negedge clk.
module pipeline_hazard_ctrl #(
    parameter int unsigned VEC_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic [3:0]  id_rs3,
    input  logic [2:0]  id_rs_used,
    input  logic [3:0]  ex_rd,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_s_write,
    input  logic        ex_reg_v_write,
    input  logic        ex_vector_op,
    input  logic        branch_taken,
    input  logic        mem_stall,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        vec_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {RUN, VBUSY} state_t;

    localparam logic [3:0] VLAT_M1   = 4'(VEC_LAT - 1);
    localparam bit         VEC_MULTI = (VEC_LAT > 1);

    state_t      state_q, state_d;
    logic [3:0]  vcnt_q, vcnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        stall_inc, flush_inc;
    logic        load_use;

    assign load_use = ex_mem_to_reg & (ex_reg_s_write | ex_reg_v_write) &
                      ((id_rs_used[0] & (id_rs1 == ex_rd)) |
                       (id_rs_used[1] & (id_rs2 == ex_rd)) |
                       (id_rs_used[2] & (id_rs3 == ex_rd)));

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        state_d       = state_q;
        vcnt_d        = vcnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (!rst || mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            stall_inc = rst;
        end else if (state_q == VBUSY) begin
            // Branch and load-use are ignored: the vector op owns EX until it drains.
            if (vcnt_q > 4'd1) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
                vcnt_d        = vcnt_q - 4'd1;
                stall_inc     = 1'b1;
            end else begin
                state_d = RUN;
                vcnt_d  = 4'd0;
            end
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (ex_vector_op && VEC_MULTI) begin
            // Also covers a concurrent load-use: the vector stall outlasts it.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = VBUSY;
            vcnt_d        = VLAT_M1;
            stall_inc     = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            vcnt_q      <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            if (stall_inc && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_inc && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign vec_busy  = rst & (state_q == VBUSY);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a VEC_LAT=1 copy shares the inputs.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs1, id_rs2, id_rs3, ex_rd;
    logic [2:0]  id_rs_used;
    logic        ex_mem_to_reg, ex_reg_s_write, ex_reg_v_write, ex_vector_op;
    logic        branch_taken, mem_stall;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_bubble, vec_busy;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_bubble, s_vec_busy;
    logic [15:0] s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] exp_stall, exp_flush;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, bubble, vec_busy}
    localparam logic [8:0] O_ZERO = 9'b00000_000_0;
    localparam logic [8:0] O_DEF  = 9'b11111_000_0;
    localparam logic [8:0] O_VDEF = 9'b11111_000_1;
    localparam logic [8:0] O_VST0 = 9'b00011_001_0;
    localparam logic [8:0] O_VST1 = 9'b00011_001_1;
    localparam logic [8:0] O_LU   = 9'b00111_010_0;
    localparam logic [8:0] O_BR   = 9'b11111_110_0;
    localparam logic [8:0] O_MS1  = 9'b00000_000_1;

    wire [8:0] outs   = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                         if_id_flush, id_ex_flush, ex_mem_bubble, vec_busy};
    wire [8:0] s_outs = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                         s_if_id_flush, s_id_ex_flush, s_ex_mem_bubble, s_vec_busy};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.VEC_LAT(3)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_s_write(ex_reg_s_write), .ex_reg_v_write(ex_reg_v_write),
        .ex_vector_op(ex_vector_op), .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .vec_busy(vec_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.VEC_LAT(1)) dut_s (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_s_write(ex_reg_s_write), .ex_reg_v_write(ex_reg_v_write),
        .ex_vector_op(ex_vector_op), .branch_taken(branch_taken), .mem_stall(mem_stall),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .ex_mem_bubble(s_ex_mem_bubble), .vec_busy(s_vec_busy),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next state-update edge and settle.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 4'd0; id_rs2 = 4'd0; id_rs3 = 4'd0; id_rs_used = 3'b000;
        ex_rd = 4'd0; ex_mem_to_reg = 1'b0; ex_reg_s_write = 1'b0; ex_reg_v_write = 1'b0;
        ex_vector_op = 1'b0; branch_taken = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] rd, input logic vwr);
        ex_rd = rd; ex_mem_to_reg = 1'b1; ex_reg_s_write = ~vwr; ex_reg_v_write = vwr;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        #1;
        chk("rst_outs_pre", {7'd0, outs}, {7'd0, O_ZERO});
        cyc(); cyc();
        chk("rst_outs", {7'd0, outs}, {7'd0, O_ZERO});
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_flush", flush_cnt, 16'd0);
        rst = 1'b1; #1;
        chk("idle_def", {7'd0, outs}, {7'd0, O_DEF});
        exp_stall = 16'd0; exp_flush = 16'd0;

        // Load-use on rs2
        set_load(4'd5, 1'b0); id_rs2 = 4'd5; id_rs_used = 3'b010; #1;
        chk("lu_rs2", {7'd0, outs}, {7'd0, O_LU});
        cyc(); exp_stall++;
        chk("lu_stall", stall_cnt, exp_stall);
        clr(); #1;
        chk("lu_after", {7'd0, outs}, {7'd0, O_DEF});
        cyc();
        chk("lu_after_cnt", stall_cnt, exp_stall);

        // Matching index but source not used -> no hazard
        set_load(4'd5, 1'b0); id_rs1 = 4'd4; id_rs2 = 4'd5; id_rs_used = 3'b001; #1;
        chk("lu_unused", {7'd0, outs}, {7'd0, O_DEF});
        // Load with no register write -> no hazard
        id_rs_used = 3'b010; ex_reg_s_write = 1'b0; #1;
        chk("lu_nowrite", {7'd0, outs}, {7'd0, O_DEF});
        cyc();
        // Vector load on rs3
        clr(); set_load(4'd7, 1'b1); id_rs3 = 4'd7; id_rs_used = 3'b100; #1;
        chk("lu_rs3_v", {7'd0, outs}, {7'd0, O_LU});
        cyc(); exp_stall++;
        chk("lu_rs3_cnt", stall_cnt, exp_stall);

        // Branch beats load-use
        clr(); set_load(4'd5, 1'b0); id_rs1 = 4'd5; id_rs_used = 3'b001; branch_taken = 1'b1; #1;
        chk("br_lu", {7'd0, outs}, {7'd0, O_BR});
        cyc(); exp_flush++;
        chk("br_flush", flush_cnt, exp_flush);
        chk("br_stall", stall_cnt, exp_stall);

        // Vector op, VEC_LAT=3; load-use appearing during VBUSY is ignored
        clr(); ex_vector_op = 1'b1; #1;
        chk("vec_c0", {7'd0, outs}, {7'd0, O_VST0});
        chk("vec_lat1_scalar", {7'd0, s_outs}, {7'd0, O_DEF});
        cyc(); exp_stall++;
        set_load(4'd3, 1'b0); id_rs1 = 4'd3; id_rs_used = 3'b001; branch_taken = 1'b1; #1;
        chk("vec_c1", {7'd0, outs}, {7'd0, O_VST1});
        chk("vec_lat1_nobusy", {15'd0, s_vec_busy}, 16'd0);
        cyc(); exp_stall++;
        chk("vec_stall2", stall_cnt, exp_stall);
        chk("vec_noflush", flush_cnt, exp_flush);
        clr(); ex_vector_op = 1'b1; #1;
        chk("vec_c2", {7'd0, outs}, {7'd0, O_VDEF});
        cyc();
        clr(); #1;
        chk("vec_done", {7'd0, outs}, {7'd0, O_DEF});
        chk("vec_done_cnt", stall_cnt, exp_stall);

        // Vector start with a concurrent load-use: no extra stall afterwards
        set_load(4'd2, 1'b0); id_rs2 = 4'd2; id_rs_used = 3'b010; ex_vector_op = 1'b1; #1;
        chk("vlu_c0", {7'd0, outs}, {7'd0, O_VST0});
        cyc(); exp_stall++;
        // mem_stall for 4 cycles with vcnt=2
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("vms_outs", {7'd0, outs}, {7'd0, O_MS1});
            cyc(); exp_stall++;
        end
        chk("vms_cnt", stall_cnt, exp_stall);
        mem_stall = 1'b0; #1;
        chk("vms_rel1", {7'd0, outs}, {7'd0, O_VST1});
        cyc(); exp_stall++;
        #1;
        chk("vms_rel2", {7'd0, outs}, {7'd0, O_VDEF});
        cyc();
        clr(); #1;
        chk("vms_run", {7'd0, outs}, {7'd0, O_DEF});
        chk("vms_total", stall_cnt, exp_stall);

        // mem_stall in RUN beats branch; flush_cnt holds
        branch_taken = 1'b1; mem_stall = 1'b1; #1;
        chk("ms_br", {7'd0, outs}, {7'd0, O_ZERO});
        cyc(); exp_stall++;
        chk("ms_br_stall", stall_cnt, exp_stall);
        chk("ms_br_flush", flush_cnt, exp_flush);

        // Reset during VBUSY
        clr(); ex_vector_op = 1'b1; cyc();
        #1;
        chk("rv_busy", {15'd0, vec_busy}, 16'd1);
        rst = 1'b0; #1;
        chk("rv_outs", {7'd0, outs}, {7'd0, O_ZERO});
        cyc();
        chk("rv_outs2", {7'd0, outs}, {7'd0, O_ZERO});
        chk("rv_stall", stall_cnt, 16'd0);
        chk("rv_flush", flush_cnt, 16'd0);
        clr(); rst = 1'b1; #1;
        chk("rv_release", {7'd0, outs}, {7'd0, O_DEF});

        // Saturation: drive stall_cnt up to FFFE, then past the top
        mem_stall = 1'b1;
        repeat (65534) cyc();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        cyc();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        cyc();
        chk("sat_hold", stall_cnt, 16'hFFFF);
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
